// File: rtl/bitserial_nn_pkg.sv
// Shared types and width helpers for the bit-serial NN engine and its downstream blocks.
package bitserial_nn_pkg;

  // Accumulator width: full product plus growth over the fan-in sum.
  function automatic int acc_w(input int data_w, input int n_in);
    return 2 * data_w + $clog2(n_in);
  endfunction

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/nn_argmax_classifier.sv
// Argmax over each activation vector with length checking; result valid 1 cycle after closing beat.
// Input stalls (tready=0) only while a result waits in HOLD; overlong vectors are drained to tlast.
module nn_argmax_classifier
  import bitserial_nn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_IN   = 128,
  parameter int ACC_W  = acc_w(DATA_W, N_IN),
  parameter int N_OUT  = 64,
  parameter int IDX_W  = $clog2(N_OUT),
  parameter int STAT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ACC_W-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [IDX_W-1:0]        m_res_idx,
  output logic signed [ACC_W-1:0] m_res_val,
  output logic                    m_res_err,
  output logic                    m_res_valid,
  input  logic                    m_res_ready,
  output logic [STAT_W-1:0]       vec_count,
  output logic [STAT_W-1:0]       err_count,
  output logic                    busy
);

  typedef struct packed {
    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] val;
    logic                    err;
  } res_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

  argmax_state_t           state_q, state_d;
  logic [IDX_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic signed [ACC_W-1:0] max_q;
  logic                    ovr_q;
  res_t                    res_q;

  logic                    beat, at_last, close, take, handoff;
  logic [IDX_W-1:0]        new_idx;
  logic signed [ACC_W-1:0] new_max;

  assign s_axis_tready = (state_q != HOLD);
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign at_last       = (cnt_q == LAST_IDX);
  assign close         = (state_q == SCAN) & beat & (s_axis_tlast | at_last);
  assign handoff       = (state_q == HOLD) & m_res_valid & m_res_ready;

  // First beat always loads; later beats replace only on a strictly greater value so ties keep the lowest index.
  assign take    = (cnt_q == '0) || ($signed(s_axis_tdata) > $signed(max_q));
  assign new_max = take ? s_axis_tdata : max_q;
  assign new_idx = take ? cnt_q : idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SCAN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:    if (close) state_d = HOLD;
      HOLD:    if (handoff) state_d = ovr_q ? DRAIN : SCAN;
      DRAIN:   if (beat && s_axis_tlast) state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      max_q       <= '0;
      ovr_q       <= 1'b0;
      res_q       <= '0;
      m_res_valid <= 1'b0;
      vec_count   <= '0;
      err_count   <= '0;
    end else begin
      if (state_q == SCAN && beat) begin
        if (close) begin
          res_q.idx   <= new_idx;
          res_q.val   <= new_max;
          res_q.err   <= ~(s_axis_tlast & at_last);
          ovr_q       <= ~s_axis_tlast;
          m_res_valid <= 1'b1;
          cnt_q       <= '0;
        end else begin
          max_q <= new_max;
          idx_q <= new_idx;
          cnt_q <= cnt_q + IDX_W'(1);
        end
      end
      if (handoff) begin
        m_res_valid <= 1'b0;
        vec_count   <= vec_count + STAT_W'(1);
        if (res_q.err && err_count != '1) err_count <= err_count + STAT_W'(1);
      end
      if (state_q == DRAIN && beat && s_axis_tlast) ovr_q <= 1'b0;
    end
  end

  assign m_res_idx = res_q.idx;
  assign m_res_val = res_q.val;
  assign m_res_err = res_q.err;
  assign busy      = (state_q != SCAN) || (cnt_q != '0);

endmodule
